// File: rtl/wasm_instr_loader_pkg.sv
// -----------------------------------------------------------------------------
// wasm_defines
// Shared constants for the WASM instruction loader: default instruction word
// width, instruction memory address width and capacity, and the encoding of
// the loader states.
// Ports: none (package).
// -----------------------------------------------------------------------------
package wasm_defines;

  localparam int instr_bram_width = 64;     // bits per instruction word
  localparam int instr_addr_width = 15;     // instruction memory address bits
  localparam int instr_max_words  = 32768;  // default image capacity in words

  typedef enum logic [1:0] {
    LDR_ACCUM = 2'd0,  // collecting host bytes into the word buffer
    LDR_WRITE = 2'd1,  // packed word presented to the core
    LDR_DONE  = 2'd2   // image complete, finish held
  } ldr_state_e;

endpackage

// File: rtl/wasm_instr_loader_if.sv
// -----------------------------------------------------------------------------
// wasm_instr_loader_if
// Bundles the host byte stream (valid/ready/last) and the core's instruction
// memory write port (valid/ready/addr/data/finish). Signal prefixes are as
// seen from the loader: i_* flows into the loader, o_* flows out of it.
// Modports:
//   master - the loader (consumes bytes, issues writes)
//   slave  - the environment (host link plus core)
// -----------------------------------------------------------------------------
interface wasm_instr_loader_if
  import wasm_defines::*;
#(
  parameter int DATA_W = instr_bram_width,
  parameter int ADDR_W = instr_addr_width
);

  logic              i_byte_vld;
  logic [7:0]        i_byte_data;
  logic              i_byte_last;
  logic              o_byte_rdy;
  logic              o_instr_mem_wr_vld;
  logic [ADDR_W-1:0] o_instr_mem_wr_addr;
  logic [DATA_W-1:0] o_instr_mem_wr_data;
  logic              i_instr_mem_wr_rdy;
  logic              o_instr_mem_wr_finish;

  modport master (
    input  i_byte_vld, i_byte_data, i_byte_last, i_instr_mem_wr_rdy,
    output o_byte_rdy, o_instr_mem_wr_vld, o_instr_mem_wr_addr,
           o_instr_mem_wr_data, o_instr_mem_wr_finish
  );

  modport slave (
    output i_byte_vld, i_byte_data, i_byte_last, i_instr_mem_wr_rdy,
    input  o_byte_rdy, o_instr_mem_wr_vld, o_instr_mem_wr_addr,
           o_instr_mem_wr_data, o_instr_mem_wr_finish
  );

endinterface

// File: rtl/wasm_instr_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Packs bytes little-endian into a DATA_W word: byte index k lands in bits
// [8k+7:8k]. When the last byte of the image arrives before the word is full,
// the remaining higher bytes are filled with PAD_BYTE on the same edge.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_clr         return the byte index to 0 (word written or load restarted)
//   i_load        store i_byte at the current index
//   i_last        current byte is the final byte of the image
//   i_byte        byte to store
//   o_word_done   the byte being stored completes the word
//   o_data        packed word
// -----------------------------------------------------------------------------
module byte_packer #(
  parameter int         DATA_W   = 64,
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic              i_last,
  input  logic [7:0]        i_byte,
  output logic              o_word_done,
  output logic [DATA_W-1:0] o_data
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [IDX_W-1:0]  idx_q,  idx_d;
  logic [DATA_W-1:0] data_q, data_d;

  // A last byte at the top index is an ordinary full word: no padding needed.
  assign o_word_done = i_last || (idx_q == IDX_W'(BYTES - 1));
  assign o_data      = data_q;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    idx_d  = idx_q;
    data_d = data_q;
    if (i_clr) begin
      idx_d = '0;
    end else if (i_load) begin
      for (int k = 0; k < BYTES; k++) begin
        if (k == int'(idx_q)) begin
          data_d[8*k +: 8] = i_byte;
        end else if (i_last && (k > int'(idx_q))) begin
          data_d[8*k +: 8] = PAD_BYTE;
        end
      end
      idx_d = o_word_done ? '0 : idx_q + IDX_W'(1);
    end
  end

  // NOTE: the word buffer is a plain register bank, not a memory array, so it
  // is cleared by reset along with the index and reads back as zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      idx_q  <= idx_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/wasm_instr_loader.sv
// -----------------------------------------------------------------------------
// wasm_instr_loader
// Feeds the WASM core's instruction memory from a host byte stream. Bytes are
// packed little-endian into DATA_W words, written to consecutive addresses
// from 0 through the core's wr_vld/wr_rdy handshake, and wr_finish is raised
// after the word carrying the last byte. Bytes beyond MAX_WORDS are consumed
// and dropped, setting a sticky overflow flag.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_restart     one-cycle pulse: abandon everything and start a new load
//   ldr_bus       byte stream in, instruction memory write out (master side)
//   o_word_cnt    words written so far
//   o_byte_sum    modulo-2^16 sum of accepted (not dropped) bytes
//   o_overflow    sticky: bytes arrived after MAX_WORDS words were written
// -----------------------------------------------------------------------------
module wasm_instr_loader
  import wasm_defines::*;
#(
  parameter int         DATA_W    = instr_bram_width,
  parameter int         ADDR_W    = instr_addr_width,
  parameter int         MAX_WORDS = instr_max_words,
  parameter logic [7:0] PAD_BYTE  = 8'h00
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_restart,
  wasm_instr_loader_if.master  ldr_bus,
  output logic [ADDR_W:0]      o_word_cnt,
  output logic [15:0]          o_byte_sum,
  output logic                 o_overflow
);

  localparam int CNT_W = ADDR_W + 1;

  ldr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [15:0]       sum_q,   sum_d;
  logic              ovf_q,   ovf_d;
  logic              last_q,  last_d;   // current word carries the final byte
  logic              pk_clr, pk_load, pk_word_done;

  // Reset is folded in so ready reads low while reset is held.
  assign ldr_bus.o_byte_rdy = (state_q == LDR_ACCUM) && !i_restart && !i_rst;

  // Valid and finish come straight from the state register, so an
  // asynchronous reset drops them immediately.
  assign ldr_bus.o_instr_mem_wr_vld    = (state_q == LDR_WRITE);
  assign ldr_bus.o_instr_mem_wr_finish = (state_q == LDR_DONE);
  assign ldr_bus.o_instr_mem_wr_addr   = addr_q;
  assign o_word_cnt = cnt_q;
  assign o_byte_sum = sum_q;
  assign o_overflow = ovf_q;

  byte_packer #(
    .DATA_W   (DATA_W),
    .PAD_BYTE (PAD_BYTE)
  ) u_packer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clr       (pk_clr),
    .i_load      (pk_load),
    .i_last      (ldr_bus.i_byte_last),
    .i_byte      (ldr_bus.i_byte_data),
    .o_word_done (pk_word_done),
    .o_data      (ldr_bus.o_instr_mem_wr_data)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    last_d  = last_q;
    pk_clr  = 1'b0;
    pk_load = 1'b0;

    if (i_restart) begin
      state_d = LDR_ACCUM;
      addr_d  = '0;
      cnt_d   = '0;
      sum_d   = '0;
      ovf_d   = 1'b0;
      last_d  = 1'b0;
      pk_clr  = 1'b1;
    end else begin
      unique case (state_q)
        LDR_ACCUM: begin
          if (ldr_bus.i_byte_vld) begin
            if (cnt_q == CNT_W'(MAX_WORDS)) begin
              // Memory full: consume and drop; a last byte still ends the load.
              ovf_d = 1'b1;
              if (ldr_bus.i_byte_last) state_d = LDR_DONE;
            end else begin
              pk_load = 1'b1;
              sum_d   = sum_q + {8'h00, ldr_bus.i_byte_data};
              last_d  = ldr_bus.i_byte_last;
              if (pk_word_done) state_d = LDR_WRITE;
            end
          end
        end
        LDR_WRITE: begin
          if (ldr_bus.i_instr_mem_wr_rdy) begin
            cnt_d  = cnt_q + CNT_W'(1);
            // Hold at the top word so the address never wraps back to 0.
            if (addr_q != ADDR_W'(MAX_WORDS - 1)) addr_d = addr_q + ADDR_W'(1);
            pk_clr  = 1'b1;
            state_d = last_q ? LDR_DONE : LDR_ACCUM;
          end
        end
        default: ;  // LDR_DONE: hold until restart or reset
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= LDR_ACCUM;
      addr_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
    end
  end

endmodule
